// File: rtl/key_sched_seq.sv
// key_sched_seq: sequential Twofish 128-bit key schedule.
// The block accepts a user key and produces the 40 expanded subkeys K[0..39]
// at one pair per cycle from a single combinational h_function instance.
// It also provides a registered read port for the downstream encrypt datapath.
// Optional feature: define KS_ZEROIZE_EN to add the zeroize input, which
// synchronously wipes the key material.
//
// Handshake: a key is accepted on a rising clk edge where key_valid and
// key_ready are both 1. key_ready is 0 while generating, so key_valid during
// generation is dropped (never queued). The producer may hold key_valid for
// as long as it likes.

// Combinational Twofish h-based subkey pair generator for a 128-bit key.
// k0 = K[2i], k1 = K[2i+1]; key words M0..M3 are m[31:0] .. m[127:96].
module h_function (
  input  logic [4:0]   i,
  input  logic [127:0] m,
  output logic [31:0]  k0,
  output logic [31:0]  k1
);
  // q-permutation nibble tables, entry n at bits [4n+3:4n].
  localparam logic [63:0] Q0_T0 = 64'h4ACE_95B0_23F6_D718;
  localparam logic [63:0] Q0_T1 = 64'hD907_6A4F_5321_8BCE;
  localparam logic [63:0] Q0_T2 = 64'h1742_3F8C_09D6_E5AB;
  localparam logic [63:0] Q0_T3 = 64'hAC58_03B9_E621_4F7D;
  localparam logic [63:0] Q1_T0 = 64'h5CA0_4913_E67F_DB82;
  localparam logic [63:0] Q1_T1 = 64'h809F_5AD6_73C4_B2E1;
  localparam logic [63:0] Q1_T2 = 64'hF3B2_8DE0_A961_57C4;
  localparam logic [63:0] Q1_T3 = 64'hA802_F746_ED3C_159B;

  function automatic logic [3:0] ror4(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

  // sel=0 selects q0, sel=1 selects q1.
  function automatic logic [7:0] qperm(input logic sel, input logic [7:0] x);
    logic [63:0] t0, t1, t2, t3;
    logic [3:0]  a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
    t0 = sel ? Q1_T0 : Q0_T0;
    t1 = sel ? Q1_T1 : Q0_T1;
    t2 = sel ? Q1_T2 : Q0_T2;
    t3 = sel ? Q1_T3 : Q0_T3;
    a0 = x[7:4];
    b0 = x[3:0];
    a1 = a0 ^ b0;
    b1 = a0 ^ ror4(b0) ^ {a0[0], 3'b000};
    a2 = t0[{a1, 2'b00} +: 4];
    b2 = t1[{b1, 2'b00} +: 4];
    a3 = a2 ^ b2;
    b3 = a2 ^ ror4(b2) ^ {a2[0], 3'b000};
    a4 = t2[{a3, 2'b00} +: 4];
    b4 = t3[{b3, 2'b00} +: 4];
    return {b4, a4};
  endfunction

  // GF(2^8) multiply modulo x^8+x^6+x^5+x^3+1 (the MDS field).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, p;
    acc = '0;
    p   = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) acc = acc ^ p;
      p = p[7] ? ({p[6:0], 1'b0} ^ 8'h69) : {p[6:0], 1'b0};
    end
    return acc;
  endfunction

  // h(X, L) for a two-word L, with X = x replicated in all four bytes.
  function automatic logic [31:0] h_word(input logic [7:0] x,
                                         input logic [31:0] l0,
                                         input logic [31:0] l1);
    logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
    y0 = qperm(1'b1, qperm(1'b0, qperm(1'b0, x) ^ l1[7:0])   ^ l0[7:0]);
    y1 = qperm(1'b0, qperm(1'b0, qperm(1'b1, x) ^ l1[15:8])  ^ l0[15:8]);
    y2 = qperm(1'b1, qperm(1'b1, qperm(1'b0, x) ^ l1[23:16]) ^ l0[23:16]);
    y3 = qperm(1'b0, qperm(1'b1, qperm(1'b1, x) ^ l1[31:24]) ^ l0[31:24]);
    z0 = y0 ^ gf_mul(y1, 8'hEF) ^ gf_mul(y2, 8'h5B) ^ gf_mul(y3, 8'h5B);
    z1 = gf_mul(y0, 8'h5B) ^ gf_mul(y1, 8'hEF) ^ gf_mul(y2, 8'hEF) ^ y3;
    z2 = gf_mul(y0, 8'hEF) ^ gf_mul(y1, 8'h5B) ^ y2 ^ gf_mul(y3, 8'hEF);
    z3 = gf_mul(y0, 8'hEF) ^ y1 ^ gf_mul(y2, 8'hEF) ^ gf_mul(y3, 8'h5B);
    return {z3, z2, z1, z0};
  endfunction

  logic [31:0] a_w, b_raw, b_w, sum2;

  // A from even key words, B from odd key words, then the PHT and rotations.
  always_comb begin
    a_w   = h_word({2'b00, i, 1'b0}, m[31:0],  m[95:64]);
    b_raw = h_word({2'b00, i, 1'b1}, m[63:32], m[127:96]);
    b_w   = {b_raw[23:0], b_raw[31:24]};
    k0    = a_w + b_w;
    sum2  = a_w + {b_w[30:0], 1'b0};
    k1    = {sum2[22:0], sum2[31:23]};
  end
endmodule

module key_sched_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  output logic         done,
  input  logic [5:0]   rd_idx,
  output logic [31:0]  rd_key
`ifdef KS_ZEROIZE_EN
  ,
  input  logic         zeroize
`endif
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GEN   = 2'd1;
  localparam logic [1:0] READY = 2'd2;
  localparam int         NUM_K = 40;

  logic [1:0]   state_q, state_d;
  logic [4:0]   i_q, i_d;
  logic [127:0] key_q, key_d;
  logic [31:0]  k_q [NUM_K];
  logic [31:0]  k_d [NUM_K];
  logic [31:0]  rd_key_q, rd_key_d;
  logic         done_q, done_d;
  logic [31:0]  h_k0, h_k1;
  logic         accept;
  logic         zero_req;

`ifdef KS_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  h_function u_h (
    .i  (i_q),
    .m  (key_q),
    .k0 (h_k0),
    .k1 (h_k1)
  );

  // Ready is withheld during reset so every output reads 0 while rst_n is low.
  assign key_ready  = rst_n && (state_q != GEN);
  assign busy       = (state_q == GEN);
  assign keys_valid = (state_q == READY);
  assign done       = done_q;
  assign rd_key     = rd_key_q;
  assign accept     = key_valid && key_ready;

  // Next-state: accept, one pair write per GEN cycle, zeroize overriding all.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    key_d    = key_q;
    k_d      = k_q;
    done_d   = 1'b0;
    rd_key_d = (rd_idx < 6'd40) ? k_q[rd_idx] : '0;
    case (state_q)
      IDLE, READY: begin
        if (accept) begin
          key_d   = key;
          i_d     = '0;
          state_d = GEN;
        end
      end
      GEN: begin
        k_d[{i_q, 1'b0}] = h_k0;
        k_d[{i_q, 1'b1}] = h_k1;
        if (i_q == 5'd19) begin
          // Counter parks at 19; the next accept reloads it.
          state_d = READY;
          done_d  = 1'b1;
        end else begin
          i_d = i_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (zero_req) begin
      state_d  = IDLE;
      i_d      = '0;
      key_d    = '0;
      done_d   = 1'b0;
      rd_key_d = '0;
      for (int n = 0; n < NUM_K; n++) k_d[n] = '0;
    end
  end

  // State, counter, key, subkey file and read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      key_q    <= '0;
      rd_key_q <= '0;
      done_q   <= 1'b0;
      for (int n = 0; n < NUM_K; n++) k_q[n] <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      key_q    <= key_d;
      rd_key_q <= rd_key_d;
      done_q   <= done_d;
      for (int n = 0; n < NUM_K; n++) k_q[n] <= k_d[n];
    end
  end
endmodule

// File: tb/tb_key_sched_seq.sv
// tb_key_sched_seq: randomized and directed bench for key_sched_seq with a
// behavioural Twofish key-schedule model and a per-cycle output compare.
module tb_key_sched_seq;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] key = '0;
  logic         key_valid = 1'b0;
  logic         key_ready, busy, keys_valid, done;
  logic [5:0]   rd_idx = '0;
  logic [31:0]  rd_key;
  logic         zeroize = 1'b0;

  key_sched_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .done       (done),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
`ifdef KS_ZEROIZE_EN
    ,
    .zeroize    (zeroize)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference Twofish math ----------------
  int qt [2][4][16] = '{
    '{ '{8,1,7,13,6,15,3,2,0,11,5,9,14,12,10,4},
       '{14,12,11,8,1,2,3,5,15,4,10,6,7,0,9,13},
       '{11,10,5,14,6,13,9,0,12,8,15,3,2,4,7,1},
       '{13,7,15,4,1,2,6,14,9,11,3,0,8,5,12,10} },
    '{ '{2,8,11,13,15,7,6,14,3,1,9,4,0,10,12,5},
       '{1,14,2,11,4,12,3,7,6,13,10,5,15,9,0,8},
       '{4,12,7,5,1,6,9,10,0,14,13,8,2,11,3,15},
       '{11,9,5,1,12,3,13,14,6,4,7,15,2,0,8,10} } };
  // q applied to byte column j, innermost first
  int qs  [4][3] = '{ '{0,0,1}, '{1,0,0}, '{0,1,1}, '{1,1,0} };
  int mds [4][4] = '{ '{'h01,'hEF,'h5B,'h5B}, '{'h5B,'hEF,'hEF,'h01},
                      '{'hEF,'h5B,'h01,'hEF}, '{'hEF,'h01,'hEF,'h5B} };

  function automatic int ref_q(input int w, input int x);
    int a, b, a1, b1;
    a = (x >> 4) & 15;
    b = x & 15;
    for (int r = 0; r < 2; r++) begin
      a1 = a ^ b;
      b1 = (a ^ (((b >> 1) | (b << 3)) & 15) ^ ((a << 3) & 15)) & 15;
      a  = qt[w][2*r][a1];
      b  = qt[w][2*r+1][b1];
    end
    return (b << 4) | a;
  endfunction

  function automatic int ref_gmul(input int a, input int b);
    int r;
    r = 0;
    for (int n = 0; n < 8; n++) begin
      if (((b >> n) & 1) != 0) r = r ^ a;
      a = a << 1;
      if ((a & 256) != 0) a = a ^ 'h169;
    end
    return r & 255;
  endfunction

  function automatic logic [31:0] ref_h(input int x, input logic [31:0] l0, input logic [31:0] l1);
    int y [4];
    logic [31:0] z;
    int zi;
    for (int j = 0; j < 4; j++) begin
      y[j] = ref_q(qs[j][0], x);
      y[j] = ref_q(qs[j][1], y[j] ^ int'(l1[8*j +: 8]));
      y[j] = ref_q(qs[j][2], y[j] ^ int'(l0[8*j +: 8]));
    end
    z = '0;
    for (int i = 0; i < 4; i++) begin
      zi = 0;
      for (int j = 0; j < 4; j++) zi = zi ^ ref_gmul(y[j], mds[i][j]);
      z[8*i +: 8] = zi[7:0];
    end
    return z;
  endfunction

  function automatic logic [31:0] ref_subkey(input int j, input logic [127:0] k);
    logic [31:0] a, b, t;
    int p;
    p = j / 2;
    a = ref_h(2*p,   k[31:0],  k[95:64]);
    b = ref_h(2*p+1, k[63:32], k[127:96]);
    b = {b[23:0], b[31:24]};
    if ((j % 2) == 0) return a + b;
    t = a + (b << 1);
    return {t[22:0], t[31:23]};
  endfunction

  // ---------------- behavioural model ----------------
  // Contents of K are described as: pairs with index < age hold the new key's
  // subkeys, all others still hold what was there at the accept (m_old).
  logic [31:0] m_old [40] = '{default: '0};
  logic [31:0] m_new [40] = '{default: '0};
  bit          m_active = 1'b0;
  int          m_age = 0;
  logic [31:0] m_rd;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] k_now(input int j);
    return (m_active && (j / 2) < m_age) ? m_new[j] : m_old[j];
  endfunction

  function automatic bit m_busy();
    return m_active && (m_age < 20);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_age    = 0;
      for (int j = 0; j < 40; j++) begin
        m_old[j] = '0;
        m_new[j] = '0;
      end
      exp_q.delete();
    end else begin
      m_rd = (rd_idx < 6'd40) ? k_now(int'(rd_idx)) : 32'h0;
      if (zeroize) begin
        m_rd     = '0;
        m_active = 1'b0;
        m_age    = 0;
        for (int j = 0; j < 40; j++) m_old[j] = '0;
      end else if (key_valid && !m_busy()) begin
        for (int j = 0; j < 40; j++) m_old[j] = k_now(j);
        for (int j = 0; j < 40; j++) m_new[j] = ref_subkey(j, key);
        m_active = 1'b1;
        m_age    = 0;
      end else if (m_active && m_age < 21) begin
        m_age++;
      end
      exp_q.push_back(m_rd);
    end
  end

  // ---------------- per-cycle scoreboard compare ----------------
  logic [31:0] exp_rd;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_keys_valid", {31'b0, keys_valid}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_rd_key", rd_key, 32'd0);
    end else begin
      exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
      check("busy", {31'b0, busy}, {31'b0, m_busy()});
      check("key_ready", {31'b0, key_ready}, {31'b0, !m_busy()});
      check("keys_valid", {31'b0, keys_valid}, {31'b0, m_active && m_age >= 20});
      check("done", {31'b0, done}, {31'b0, m_active && m_age == 20});
      check("rd_key", rd_key, exp_rd);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offer k; optionally keep offering k2 throughout generation.
  task automatic gen_and_check(input logic [127:0] k, input bit hold, input logic [127:0] k2);
    int busy_cnt;
    bit seen;
    busy_cnt = 0;
    seen = 1'b0;
    @(negedge clk); #1;
    key = k;
    key_valid = 1'b1;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
      #1;
      key = k2;
      key_valid = hold && !seen;
    end
    key_valid = 1'b0;
    check("busy_cycles", busy_cnt, 32'd20);
    check("done_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic read_word(input int idx, output logic [31:0] w);
    @(negedge clk); #1;
    rd_idx = idx[5:0];
    @(negedge clk);
    w = rd_key;
  endtask

  task automatic readback_all(input logic [127:0] k);
    logic [31:0] w;
    for (int idx = 0; idx < 40; idx++) begin
      read_word(idx, w);
      check($sformatf("readback_%0d", idx), w, ref_subkey(idx, k));
    end
    read_word(40, w);
    check("readback_40", w, 32'h0);
    read_word(63, w);
    check("readback_63", w, 32'h0);
  endtask

  task automatic reset_mid_gen();
    bit done_seen;
    done_seen = 1'b0;
    @(negedge clk); #1;
    key = rand128();
    key_valid = 1'b1;
    @(negedge clk); #1;
    key_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_keys_valid", {31'b0, keys_valid}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_rd_key", rd_key, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_key_ready", {31'b0, key_ready}, 32'd1);
    repeat (25) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("abort_no_done", {31'b0, done_seen}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0]  w;
  logic [127:0] ka, kb;
  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'b0, key_ready}, 32'd1);

    // Model pinned against published zero-key subkeys.
    check("model_pin_k0", ref_subkey(0, 128'h0), 32'h52C54DDE);
    check("model_pin_k1", ref_subkey(1, 128'h0), 32'h11F0626D);

    gen_and_check(128'h0, 1'b0, 128'h0);
    read_word(0, w);
    check("zero_key_k0", w, 32'h52C54DDE);
    read_word(1, w);
    check("zero_key_k1", w, 32'h11F0626D);
    readback_all(128'h0);

    ka = rand128();
    kb = rand128();
    gen_and_check(ka, 1'b1, kb);
    readback_all(ka);

    gen_and_check({128{1'b1}}, 1'b0, 128'h0);
    readback_all({128{1'b1}});

`ifdef KS_ZEROIZE_EN
    gen_and_check(rand128(), 1'b0, 128'h0);
    @(negedge clk); #1 zeroize = 1'b1;
    @(negedge clk);
    check("zeroize_keys_valid", {31'b0, keys_valid}, 32'd0);
    #1;
    key = rand128();
    key_valid = 1'b1;
    @(negedge clk);
    check("zeroize_no_accept", {31'b0, busy}, 32'd0);
    check("zeroize_no_done", {31'b0, done}, 32'd0);
    #1;
    zeroize = 1'b0;
    key_valid = 1'b0;
    read_word(0, w);
    check("zeroize_rd0", w, 32'h0);
    read_word(39, w);
    check("zeroize_rd39", w, 32'h0);
`endif

    reset_mid_gen();

    // Random traffic: sporadic offers, random read indices.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); #1;
      key_valid = ($urandom_range(0, 9) == 0);
      key = rand128();
      rd_idx = 6'($urandom_range(0, 63));
`ifdef KS_ZEROIZE_EN
      zeroize = ($urandom_range(0, 49) == 0);
`endif
    end
    @(negedge clk); #1;
    key_valid = 1'b0;
    zeroize = 1'b0;
    repeat (25) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
